console_command_sequencer: RTL



---
 rtl/console_command_sequencer_pkg.sv | 31 +++
 rtl/console_command_sequencer_if.sv | 38 +++
 rtl/command_fifo.sv | 48 ++++
 rtl/console_command_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/console_command_sequencer_pkg.sv
// Shared types for the console command sequencer: parser command encoding,
// parameter bundle, queue entry and sequencer FSM states.
package console_command_sequencer_pkg;

  typedef enum logic [4:0] {
    NOP, INPUT, CUU, CUD, CUF, CUB, CUP, ED, EL, IND, NEL, RI,
    INIT_PN, EMIT_PN, SGR, SM, RM, SCS
  } CommandsType;

  typedef struct packed {
    logic [7:0] pn1;
    logic [7:0] pn2;
    logic [7:0] pns;
    logic [7:0] pchar;
  } Param_t;

  typedef struct packed {
    CommandsType ctype;
    Param_t      param;
  } cmd_entry_t;

  typedef enum logic [2:0] {IDLE, EXEC, WRITE, ERASE, SCROLL} SeqState;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  // Movement counts of zero mean one.
  function automatic logic [8:0] count_or_one(input logic [7:0] n);
    return (n == 8'd0) ? 9'd1 : {1'b0, n};
  endfunction

endpackage

// File: rtl/console_command_sequencer_if.sv
// Parser, text-RAM, scroller and status signals of the console command sequencer.
interface console_command_sequencer_if #(
  parameter int COLS = 80,
  parameter int ROWS = 24
);
  import console_command_sequencer_pkg::*;

  localparam int AW = $clog2(ROWS * COLS);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic          cmd_valid;
  CommandsType   cmd_type;
  Param_t        cmd_param;
  logic          ram_req;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_gnt;
  logic          scroll_req;
  logic          scroll_up;
  logic          scroll_ack;
  logic [RW-1:0] cursor_row;
  logic [CW-1:0] cursor_col;
  logic          busy;
  logic          overflow;

  modport slave (
    input  cmd_valid, cmd_type, cmd_param, ram_gnt, scroll_ack,
    output ram_req, ram_addr, ram_wdata, scroll_req, scroll_up,
           cursor_row, cursor_col, busy, overflow
  );

  modport master (
    output cmd_valid, cmd_type, cmd_param, ram_gnt, scroll_ack,
    input  ram_req, ram_addr, ram_wdata, scroll_req, scroll_up,
           cursor_row, cursor_col, busy, overflow
  );
endinterface

// File: rtl/command_fifo.sv
// Power-of-two synchronous FIFO of parser commands with full/empty flags.
module command_fifo
  import console_command_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  cmd_entry_t din,
  output cmd_entry_t dout,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(DEPTH);

  cmd_entry_t  mem_q [DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end

  // Extra pointer bit distinguishes a full queue from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign dout  = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/console_command_sequencer.sv
// Buffers parser commands and executes them: cursor moves, character writes,
// blank erases through the text-RAM handshake, and scroll requests.
module console_command_sequencer
  import console_command_sequencer_pkg::*;
#(
  parameter int COLS       = 80,
  parameter int ROWS       = 24,
  parameter int FIFO_DEPTH = 4
) (
  input logic                         clk,
  input logic                         rst_n,
  console_command_sequencer_if.slave  bus
);
  localparam int AW = $clog2(ROWS * COLS);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(ROWS * COLS - 1);
  localparam logic [9:0]    ROWS_W    = 10'(ROWS);
  localparam logic [9:0]    COLS_W    = 10'(COLS);

  SeqState       state_q, state_d;
  cmd_entry_t    cmd_q, cmd_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] end_q, end_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          scroll_up_q, scroll_up_d;
  logic          overflow_q, overflow_d;

  logic          push, pop, fifo_full, fifo_empty, do_ind;
  cmd_entry_t    cmd_in, fifo_dout;
  logic [9:0]    row_w, col_w, n_w, p2_w;
  logic [AW-1:0] cur_addr, line_base, erase_lo, erase_hi;
  logic [7:0]    pchar;
  logic          unused_bits;

  assign cmd_in.ctype = bus.cmd_type;
  assign cmd_in.param = bus.cmd_param;
  assign pop  = (state_q == IDLE) && !fifo_empty;
  assign push = bus.cmd_valid && (!fifo_full || pop);

  command_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (cmd_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Cursor arithmetic is done 10 bits wide so large counts saturate, never wrap.
  assign row_w     = 10'(row_q);
  assign col_w     = 10'(col_q);
  assign n_w       = {1'b0, count_or_one(cmd_q.param.pn1)};
  assign p2_w      = {1'b0, count_or_one(cmd_q.param.pn2)};
  assign pchar     = cmd_q.param.pchar;
  assign line_base = AW'(32'(row_q) * COLS);
  assign cur_addr  = line_base + AW'(col_q);
  assign erase_lo  = (cmd_q.ctype == ED) ? '0 : line_base;
  assign erase_hi  = (cmd_q.ctype == ED) ? ADDR_LAST : line_base + AW'(COLS - 1);
  assign unused_bits = ^cmd_q.param.pns;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    row_d       = row_q;
    col_d       = col_q;
    addr_d      = addr_q;
    end_d       = end_q;
    wdata_d     = wdata_q;
    scroll_up_d = scroll_up_q;
    overflow_d  = overflow_q | (bus.cmd_valid & ~push);
    do_ind      = 1'b0;
    case (state_q)
      IDLE: if (pop) begin
        cmd_d   = fifo_dout;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = IDLE;
        case (cmd_q.ctype)
          CUU: row_d = (row_w >= n_w) ? RW'(row_w - n_w) : '0;
          CUD: row_d = (row_w + n_w >= ROWS_W) ? ROW_LAST : RW'(row_w + n_w);
          CUB: col_d = (col_w >= n_w) ? CW'(col_w - n_w) : '0;
          CUF: col_d = (col_w + n_w >= COLS_W) ? COL_LAST : CW'(col_w + n_w);
          CUP: begin
            row_d = (n_w >= ROWS_W) ? ROW_LAST : RW'(n_w - 10'd1);
            col_d = (p2_w >= COLS_W) ? COL_LAST : CW'(p2_w - 10'd1);
          end
          INPUT: begin
            if (pchar == 8'h0D) col_d = '0;
            else if (pchar == 8'h0A) do_ind = 1'b1;
            else if (pchar == 8'h08) col_d = (col_q == '0) ? '0 : col_q - CW'(1);
            else if (pchar >= 8'h20 && pchar != 8'h7F) begin
              addr_d  = cur_addr;
              wdata_d = pchar;
              state_d = WRITE;
            end
          end
          IND: do_ind = 1'b1;
          NEL: begin
            col_d  = '0;
            do_ind = 1'b1;
          end
          RI: begin
            if (row_q == '0) begin
              scroll_up_d = 1'b0;
              state_d     = SCROLL;
            end else begin
              row_d = row_q - RW'(1);
            end
          end
          ED, EL: if (cmd_q.param.pn1 <= 8'd2) begin
            addr_d  = (cmd_q.param.pn1 == 8'd0) ? cur_addr : erase_lo;
            end_d   = (cmd_q.param.pn1 == 8'd1) ? cur_addr : erase_hi;
            wdata_d = BLANK_CHAR;
            state_d = ERASE;
          end
          default: ;
        endcase
      end
      WRITE: if (bus.ram_gnt) begin
        if (col_q == COL_LAST) begin
          col_d  = '0;
          do_ind = 1'b1;
        end else begin
          col_d   = col_q + CW'(1);
          state_d = IDLE;
        end
      end
      ERASE: if (bus.ram_gnt) begin
        if (addr_q == end_q) state_d = IDLE;
        else                 addr_d  = addr_q + AW'(1);
      end
      SCROLL: if (bus.scroll_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Line feed: step down, or scroll the screen up when already at the bottom.
    if (do_ind) begin
      if (row_q == ROW_LAST) begin
        scroll_up_d = 1'b1;
        state_d     = SCROLL;
      end else begin
        row_d   = row_q + RW'(1);
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      end_q       <= '0;
      wdata_q     <= '0;
      scroll_up_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      row_q       <= row_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      end_q       <= end_d;
      wdata_q     <= wdata_d;
      scroll_up_q <= scroll_up_d;
      overflow_q  <= overflow_d;
    end
  end

  // Requests decode straight from the state so a reset drops them at once.
  assign bus.ram_req    = (state_q == WRITE) || (state_q == ERASE);
  assign bus.scroll_req = (state_q == SCROLL);
  assign bus.ram_addr   = addr_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.scroll_up  = scroll_up_q;
  assign bus.cursor_row = row_q;
  assign bus.cursor_col = col_q;
  assign bus.busy       = (state_q != IDLE) || !fifo_empty;
  assign bus.overflow   = overflow_q;

endmodule
